// File: rtl/cache_control_if.sv
// Signal bundle between the cache controller, the CPU port, the cacheline
// adaptor and the tag/valid/dirty/LRU/data arrays of a 2-way cache.
interface cache_control_if #(parameter int cnt_w = 16);
   logic             mem_read;
   logic             mem_write;
   logic [1:0]       hit;
   logic [1:0]       valid;
   logic [1:0]       dirty;
   logic             lru;
   logic             pmem_resp;
   logic             mem_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic [1:0]       load_data;
   logic [1:0]       load_tag;
   logic [1:0]       load_valid;
   logic [1:0]       load_dirty;
   logic             valid_in;
   logic             dirty_in;
   logic             load_lru;
   logic             lru_in;
   logic             way_sel;
   logic             data_in_sel;
   logic             pmem_addr_sel;
   logic [cnt_w-1:0] hit_count;
   logic [cnt_w-1:0] miss_count;

   // Controller side: consumes status, drives strobes and pmem requests.
   modport master (
      input  mem_read, mem_write, hit, valid, dirty, lru, pmem_resp,
      output mem_resp, pmem_read, pmem_write, load_data, load_tag,
             load_valid, load_dirty, valid_in, dirty_in, load_lru, lru_in,
             way_sel, data_in_sel, pmem_addr_sel, hit_count, miss_count
   );

   // Environment side: CPU, datapath arrays and cacheline adaptor.
   modport slave (
      output mem_read, mem_write, hit, valid, dirty, lru, pmem_resp,
      input  mem_resp, pmem_read, pmem_write, load_data, load_tag,
             load_valid, load_dirty, valid_in, dirty_in, load_lru, lru_in,
             way_sel, data_in_sel, pmem_addr_sel, hit_count, miss_count
   );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative write-back/write-allocate cache,
// with saturating hit/miss performance counters.
module cache_control #(
   parameter int cnt_w = 16
) (
   input  logic           clk,
   input  logic           rst,
   cache_control_if.master bus
);

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             victim_q, victim_nxt;
   logic [cnt_w-1:0] hit_cnt, miss_cnt;
   logic             hit_inc, miss_inc;
   logic             req, wr, any_hit, hit_way;

   function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
      return (&v) ? v : v + cnt_w'(1);
   endfunction

   function automatic logic [1:0] way_mask(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

   assign req     = bus.mem_read | bus.mem_write;
   assign wr      = bus.mem_write;
   assign any_hit = |bus.hit;
   assign hit_way = ~bus.hit[0];

   always_comb begin
      state_nxt         = state;
      victim_nxt        = victim_q;
      hit_inc           = 1'b0;
      miss_inc          = 1'b0;
      bus.mem_resp      = 1'b0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.load_data     = 2'b00;
      bus.load_tag      = 2'b00;
      bus.load_valid    = 2'b00;
      bus.load_dirty    = 2'b00;
      bus.valid_in      = 1'b0;
      bus.dirty_in      = 1'b0;
      bus.load_lru      = 1'b0;
      bus.lru_in        = 1'b0;
      bus.way_sel       = 1'b0;
      bus.data_in_sel   = 1'b0;
      bus.pmem_addr_sel = 1'b0;
      case (state)
         CHECK: begin
            if (req && any_hit) begin
               bus.mem_resp = 1'b1;
               bus.way_sel  = hit_way;
               bus.load_lru = 1'b1;
               bus.lru_in   = ~hit_way;
               hit_inc      = 1'b1;
               if (wr) begin
                  bus.load_data  = way_mask(hit_way);
                  bus.load_dirty = way_mask(hit_way);
                  bus.dirty_in   = 1'b1;
               end
            end else if (req) begin
               // Victim is captured here so later LRU updates cannot move it.
               miss_inc    = 1'b1;
               bus.way_sel = bus.lru;
               victim_nxt  = bus.lru;
               state_nxt   = (bus.valid[bus.lru] && bus.dirty[bus.lru]) ?
                             WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = 1'b1;
            bus.way_sel       = victim_q;
            if (bus.pmem_resp) state_nxt = ALLOCATE;
         end
         ALLOCATE: begin
            bus.pmem_read = 1'b1;
            bus.way_sel   = victim_q;
            if (bus.pmem_resp) begin
               bus.load_data   = way_mask(victim_q);
               bus.load_tag    = way_mask(victim_q);
               bus.load_valid  = way_mask(victim_q);
               bus.load_dirty  = way_mask(victim_q);
               bus.valid_in    = 1'b1;
               bus.data_in_sel = 1'b1;
               state_nxt       = CHECK;
            end
         end
         default: state_nxt = CHECK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CHECK;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (hit_inc)  hit_cnt  <= sat_inc(hit_cnt);
         if (miss_inc) miss_cnt <= sat_inc(miss_cnt);
      end
   end

   always_ff @(posedge clk) begin
      victim_q <= victim_nxt;
   end

   assign bus.hit_count  = hit_cnt;
   assign bus.miss_count = miss_cnt;

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for a 2-way set-associative, write-back, write-allocate cache.
- Sequences the per-set tag, valid, dirty and LRU register arrays and the data array: drives their load strobes and input selects from hit/valid/dirty/LRU status produced by the datapath.
- Sits between the CPU memory port and the cacheline adaptor (pmem side).
- Also keeps saturating hit and miss counters for performance monitoring.

Parameters:
cnt_w, 16, width of hit_count and miss_count performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
hit  in  2  per-way hit (tag match AND valid) for current CPU address
valid  in  2  per-way valid bits of indexed set
dirty  in  2  per-way dirty bits of indexed set
lru  in  1  LRU bit of indexed set (way to evict next)
pmem_resp  in  1  cacheline adaptor done, 1-cycle pulse
mem_resp  out  1  CPU request complete
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
load_data  out  2  per-way data array write enable
load_tag  out  2  per-way tag array write enable
load_valid  out  2  per-way valid array write enable
load_dirty  out  2  per-way dirty array write enable
valid_in  out  1  value written to valid array
dirty_in  out  1  value written to dirty array
load_lru  out  1  LRU array write enable
lru_in  out  1  value written to LRU array
way_sel  out  1  way selected for output mux / victim
data_in_sel  out  1  0 = CPU write data (byte-enabled), 1 = pmem line
pmem_addr_sel  out  1  0 = {cpu tag,index}, 1 = {victim tag,index}
hit_count  out  cnt_w  saturating hit counter
miss_count  out  cnt_w  saturating miss counter

Behaviour:
- States: CHECK, WRITEBACK, ALLOCATE. Reset → CHECK; both counters 0. All outputs combinational from state and inputs; all are 0 in any cycle with no request and no pmem activity.
- A request is mem_read | mem_write. If both are asserted, it is treated as a write.
- Hit way = 0 if hit[0], else 1. If hit == 2'b11, way 0 is used.
- Victim = lru.
- CHECK, no request: all strobes 0; stay.
- CHECK, request and |hit (0 extra cycles):
  - mem_resp=1 the same cycle.
  - way_sel = hit way; load_lru=1, lru_in = ~hit way.
  - On write, additionally: load_data[way]=1, data_in_sel=0, load_dirty[way]=1, dirty_in=1.
  - hit_count += 1 (saturating). Stay in CHECK.
- CHECK, request and no hit:
  - miss_count += 1 (saturating), counted once per miss.
  - way_sel = victim.
  - Next state is WRITEBACK if valid[victim] & dirty[victim], else ALLOCATE. mem_resp=0.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim. Wait for pmem_resp, then → ALLOCATE. Victim is latched on CHECK exit, so an LRU change cannot alter it.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0, way_sel=latched victim. On pmem_resp, in one cycle:
  - load_data[v]=1 with data_in_sel=1.
  - load_tag[v]=1.
  - load_valid[v]=1 with valid_in=1.
  - load_dirty[v]=1 with dirty_in=0.
  - → CHECK.
  - The next CHECK cycle hits and completes the request there; the hit counter increments for that completion as well.
- pmem_read/pmem_write stay high continuously until pmem_resp. They are never both high.
- Request deasserted mid-miss (protocol violation): the fill/writeback still completes, then the FSM returns to CHECK idle.
- Reset mid-WRITEBACK/ALLOCATE: next state CHECK; pmem strobes low the cycle after rst is sampled; counters cleared. Array contents are the arrays' own reset responsibility.
- Counters hold at 2^cnt_w-1; no wrap.
- Latency:
  - Hit: 1 cycle.
  - Clean miss: 1 + fill + 1.
  - Dirty miss: 1 + writeback + fill + 1.

Test Plan:
- Reset, then idle 5 cycles → every strobe 0, counters 0, state CHECK.
- mem_read with hit=2'b10 → mem_resp same cycle, way_sel=1, load_lru=1, lru_in=0, hit_count=1, no load_data.
- mem_write with hit=2'b01 → mem_resp, load_data=2'b01, load_dirty=2'b01, dirty_in=1, data_in_sel=0, lru_in=1.
- Clean miss: mem_read, hit=0, lru=1, valid=2'b10, dirty=2'b00.
  - Next cycle pmem_read=1 held for 4 cycles; pmem_resp → load_data/tag/valid/dirty=2'b10, dirty_in=0, data_in_sel=1.
  - Then drive hit=2'b10 → mem_resp; miss_count=1, hit_count=1.
- Dirty miss: lru=0, valid=2'b01, dirty=2'b01 → pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read. Drive lru=1 during WRITEBACK → fill still loads way 0.
- Assert rst during ALLOCATE → pmem_read=0 next cycle, counters 0. Preload hit_count to 2^16-1 via hits → further hits keep 16'hFFFF.
